mem_write_checker: RTL and testbench

Synthesizable, parametrised self-check monitor for the pipelined processor's data-memory write port. Watches every store (`mem_write`, `data_adr`, `write_data`) and classifies the run as PASS, FAIL or TIMEOUT. Failure stores can be ignored over an address window, and a cycle watchdog catches hangs. The block sits beside the processor on the DE0-Nano top. Its sticky verdict and captured failing store can drive LEDs or GPIO in hardware, and the simulation bench can sample them.

---
 rtl/mem_check_pkg.sv | 49 ++++
 rtl/sat_counter.sv | 45 ++++
 rtl/mem_write_checker.sv | 185 ++++++++++++++++++
 tb/tb_mem_write_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_check_pkg
//  Description : Shared types for the data-memory write checker: checker
//                state, externally visible status codes and store classes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_check_pkg;

    // Checker state; TOUT is kept distinct internally even though it shares
    // the status code of FAIL on the outside.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TOUT = 3'd4
    } chk_state_t;

    // Codes presented on the status output.
    localparam logic [1:0] STATUS_IDLE = 2'd0;
    localparam logic [1:0] STATUS_RUN  = 2'd1;
    localparam logic [1:0] STATUS_PASS = 2'd2;
    localparam logic [1:0] STATUS_STOP = 2'd3;

    // Classification of the store presented in the current cycle.
    typedef enum logic [1:0] {
        SK_NONE    = 2'd0,
        SK_PASS    = 2'd1,
        SK_IGNORED = 2'd2,
        SK_ILLEGAL = 2'd3
    } store_kind_t;

    // Map a checker state to its status code (FAIL and TOUT both read 3).
    function automatic logic [1:0] status_of(input chk_state_t s);
        logic [1:0] code;
        code = STATUS_IDLE;
        case (s)
            ST_RUN:  code = STATUS_RUN;
            ST_PASS: code = STATUS_PASS;
            ST_FAIL: code = STATUS_STOP;
            ST_TOUT: code = STATUS_STOP;
            default: code = STATUS_IDLE;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//                Synchronous clear has priority over increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] C_MAX = {W{1'b1}};

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear, else step unless already saturated.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != C_MAX)) begin
            q_d = q_q + W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/mem_write_checker.sv
`default_nettype none
// ============================================================================
//  Module      : mem_write_checker
//  Description : Watches the processor data-memory write port and latches a
//                sticky PASS / FAIL / TIMEOUT verdict, plus the first
//                failing store and run statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_write_checker
    import mem_check_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 16,
    parameter int PASS_ADDR   = 55,
    parameter int PASS_DATA   = 1,
    parameter int IGN_BASE    = 96,
    parameter int IGN_COUNT   = 1,
    parameter int STRICT      = 1,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              clr,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [1:0]        status,
    output logic [CNT_W-1:0]  write_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W-1:0] fail_adr,
    output logic [DATA_W-1:0] fail_data
);

    localparam logic [ADDR_W-1:0] C_PASS_ADDR = ADDR_W'(PASS_ADDR);
    localparam logic [DATA_W-1:0] C_PASS_DATA = DATA_W'(PASS_DATA);
    // Window bounds carry one extra bit so base+count never wraps to zero.
    localparam logic [ADDR_W:0]   C_IGN_LO    = (ADDR_W+1)'(IGN_BASE);
    localparam logic [ADDR_W:0]   C_IGN_HI    = (ADDR_W+1)'(IGN_BASE + IGN_COUNT);
    localparam longint            C_WD_LAST   = (TIMEOUT_CYC == 0) ? 64'd0 : 64'(TIMEOUT_CYC - 1);

    chk_state_t        state_q, state_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic [1:0]        status_q, status_d;
    logic [ADDR_W-1:0] fail_adr_q, fail_adr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    store_kind_t       w_kind;
    logic [ADDR_W:0]   w_adr_ext;
    logic              w_pass_hit;
    logic              w_ign_hit;
    logic              w_in_run;
    logic              w_wd_fire;
    logic [CNT_W-1:0]  w_write_count;
    logic [CNT_W-1:0]  w_cycle_count;

    assign w_in_run   = (state_q == ST_RUN);
    assign w_adr_ext  = {1'b0, data_adr};
    assign w_pass_hit = (data_adr == C_PASS_ADDR) && (write_data == C_PASS_DATA);
    assign w_ign_hit  = (IGN_COUNT != 0) && (w_adr_ext >= C_IGN_LO) && (w_adr_ext < C_IGN_HI);
    // Expiry is judged on the count before this edge's increment.
    assign w_wd_fire  = (TIMEOUT_CYC != 0) && (64'(w_cycle_count) == C_WD_LAST);

    // Classify the store on the bus; pass match outranks the ignore window,
    // and in lenient mode unmatched stores are simply tolerated.
    always_comb begin
        w_kind = SK_NONE;
        if (mem_write) begin
            if (w_pass_hit) begin
                w_kind = SK_PASS;
            end else if (w_ign_hit) begin
                w_kind = SK_IGNORED;
            end else if (STRICT != 0) begin
                w_kind = SK_ILLEGAL;
            end else begin
                w_kind = SK_IGNORED;
            end
        end
    end

    // Verdict FSM next state, failing-store capture and registered flags.
    always_comb begin
        state_d     = state_q;
        fail_adr_d  = fail_adr_q;
        fail_data_d = fail_data_q;
        if (clr) begin
            state_d     = ST_IDLE;
            fail_adr_d  = '0;
            fail_data_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_kind == SK_PASS) begin
                        state_d = ST_PASS;
                    end else if (w_kind == SK_ILLEGAL) begin
                        state_d     = ST_FAIL;
                        fail_adr_d  = data_adr;
                        fail_data_d = write_data;
                    end else if (w_wd_fire) begin
                        state_d = ST_TOUT;
                    end
                end
                ST_PASS, ST_FAIL, ST_TOUT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        pass_d    = (state_d == ST_PASS);
        fail_d    = (state_d == ST_FAIL);
        timeout_d = (state_d == ST_TOUT);
        done_d    = pass_d | fail_d | timeout_d;
        status_d  = status_of(state_d);
    end

    // Single clocked process for state, flags and capture registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            status_q    <= STATUS_IDLE;
            fail_adr_q  <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            status_q    <= status_d;
            fail_adr_q  <= fail_adr_d;
            fail_data_q <= fail_data_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_write_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (w_in_run & mem_write),
        .q     (w_write_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (w_in_run),
        .q     (w_cycle_count)
    );

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign status      = status_q;
    assign write_count = w_write_count;
    assign cycle_count = w_cycle_count;
    assign fail_adr    = fail_adr_q;
    assign fail_data   = fail_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_write_checker
//  Description : Bench for mem_write_checker. Three instances with different
//                configurations share one stimulus stream; each is compared
//                against its own behavioural model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic        clr = 1'b0;
    logic        mem_write = 1'b0;
    logic [12:0] data_adr = '0;
    logic [15:0] write_data = '0;

    int checks = 0;
    int errors = 0;

    // Instance 0: strict, window 96..99, watchdog 8.
    wire        done_s, pass_s, fail_s, tout_s;
    wire [1:0]  status_s;
    wire [23:0] wc_s, cc_s;
    wire [12:0] fa_s;
    wire [15:0] fd_s;
    // Instance 1: lenient, default window, no watchdog.
    wire        done_n, pass_n, fail_n, tout_n;
    wire [1:0]  status_n;
    wire [23:0] wc_n, cc_n;
    wire [12:0] fa_n;
    wire [15:0] fd_n;
    // Instance 2: strict, window 96..111, 3-bit counters, no watchdog.
    wire        done_c, pass_c, fail_c, tout_c;
    wire [1:0]  status_c;
    wire [2:0]  wc_c, cc_c;
    wire [12:0] fa_c;
    wire [15:0] fd_c;

    always #5 clk = ~clk;

    mem_write_checker #(.STRICT(1), .IGN_BASE(96), .IGN_COUNT(4), .TIMEOUT_CYC(8)) dut_s (
        .clk(clk), .reset(reset), .arm(arm), .clr(clr), .mem_write(mem_write),
        .data_adr(data_adr), .write_data(write_data), .done(done_s), .pass(pass_s),
        .fail(fail_s), .timeout(tout_s), .status(status_s), .write_count(wc_s),
        .cycle_count(cc_s), .fail_adr(fa_s), .fail_data(fd_s));

    mem_write_checker #(.STRICT(0), .TIMEOUT_CYC(0)) dut_n (
        .clk(clk), .reset(reset), .arm(arm), .clr(clr), .mem_write(mem_write),
        .data_adr(data_adr), .write_data(write_data), .done(done_n), .pass(pass_n),
        .fail(fail_n), .timeout(tout_n), .status(status_n), .write_count(wc_n),
        .cycle_count(cc_n), .fail_adr(fa_n), .fail_data(fd_n));

    mem_write_checker #(.STRICT(1), .IGN_BASE(96), .IGN_COUNT(16), .TIMEOUT_CYC(0), .CNT_W(3)) dut_c (
        .clk(clk), .reset(reset), .arm(arm), .clr(clr), .mem_write(mem_write),
        .data_adr(data_adr), .write_data(write_data), .done(done_c), .pass(pass_c),
        .fail(fail_c), .timeout(tout_c), .status(status_c), .write_count(wc_c),
        .cycle_count(cc_c), .fail_adr(fa_c), .fail_data(fd_c));

    // ---------------- behavioural reference model ----------------
    // st: 0 idle, 1 running, 2 passed, 3 failed, 4 timed out
    typedef struct {
        bit strict;
        int ign_base;
        int ign_count;
        int tout;
        int cmax;
    } cfg_t;

    typedef struct {
        int st;
        int wc;
        int cc;
        int fa;
        int fd;
    } mdl_t;

    cfg_t cfg[3];
    mdl_t m[3];

    function automatic mdl_t step(cfg_t c, mdl_t s, bit rn, bit cl, bit ar, bit mw, int adr, int dat);
        mdl_t n;
        bit   is_pass, in_win, bad, expire;
        n = s;
        if (!rn || cl) begin
            n.st = 0; n.wc = 0; n.cc = 0; n.fa = 0; n.fd = 0;
            return n;
        end
        if (s.st == 0) begin
            if (ar) n.st = 1;
        end else if (s.st == 1) begin
            is_pass = mw && (adr == 55) && (dat == 1);
            in_win  = mw && (adr >= c.ign_base) && (adr < c.ign_base + c.ign_count);
            bad     = mw && !is_pass && !in_win && c.strict;
            expire  = (c.tout != 0) && (s.cc == c.tout - 1);
            if (mw && s.wc < c.cmax) n.wc = s.wc + 1;
            if (s.cc < c.cmax) n.cc = s.cc + 1;
            if (is_pass) n.st = 2;
            else if (bad) begin
                n.st = 3; n.fa = adr; n.fd = dat;
            end else if (expire) n.st = 4;
        end
        return n;
    endfunction

    function automatic logic [95:0] pack_exp(mdl_t s);
        logic [3:0] flags;
        logic [1:0] stat;
        flags = {s.st >= 2, s.st == 2, s.st == 3, s.st == 4};
        stat  = (s.st == 4) ? 2'd3 : 2'(s.st);
        return {4'b0, flags, 6'b0, stat, 24'(s.wc), 24'(s.cc), 16'(s.fa), 16'(s.fd)};
    endfunction

    function automatic logic [95:0] pack_act(int i);
        case (i)
            0: return {4'b0, done_s, pass_s, fail_s, tout_s, 6'b0, status_s, wc_s, cc_s, 3'b0, fa_s, fd_s};
            1: return {4'b0, done_n, pass_n, fail_n, tout_n, 6'b0, status_n, wc_n, cc_n, 3'b0, fa_n, fd_n};
            default: return {4'b0, done_c, pass_c, fail_c, tout_c, 6'b0, status_c, 21'b0, wc_c, 21'b0, cc_c, 3'b0, fa_c, fd_c};
        endcase
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the models, compare at the negedge.
    task automatic cyc(input bit rn, input bit cl, input bit ar, input bit mw, input int adr, input int dat);
        reset = rn; clr = cl; arm = ar; mem_write = mw;
        data_adr = 13'(adr); write_data = 16'(dat);
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = step(cfg[i], m[i], rn, cl, ar, mw, adr, dat);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("model_dut%0d", i), pack_act(i), pack_exp(m[i]));
    endtask

    // ---------------- directed vector table (instance 0) ----------------
    typedef struct {
        bit         rn, cl, ar, mw;
        int         adr, dat;
        int         e_st;
        logic [3:0] e_flags;   // done, pass, fail, timeout
        int         e_wc, e_fa, e_fd;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(bit rn, bit cl, bit ar, bit mw, int adr, int dat,
                                int st, logic [3:0] fl, int wc, int fa, int fd);
        vec_t v;
        v.rn = rn; v.cl = cl; v.ar = ar; v.mw = mw; v.adr = adr; v.dat = dat;
        v.e_st = st; v.e_flags = fl; v.e_wc = wc; v.e_fa = fa; v.e_fd = fd;
        return v;
    endfunction

    initial begin
        logic [95:0] a;
        logic [95:0] e;
        int          radr, rdat;

        cfg[0] = '{strict: 1'b1, ign_base: 96, ign_count: 4,  tout: 8, cmax: 24'hFFFFFF};
        cfg[1] = '{strict: 1'b0, ign_base: 96, ign_count: 1,  tout: 0, cmax: 24'hFFFFFF};
        cfg[2] = '{strict: 1'b1, ign_base: 96, ign_count: 16, tout: 0, cmax: 7};
        for (int i = 0; i < 3; i++) m[i] = '{st: 0, wc: 0, cc: 0, fa: 0, fd: 0};

        vecs[0]  = mk(0,0,0,0,   0,0, 0,4'b0000,0,  0,0);
        vecs[1]  = mk(1,0,1,0,   0,0, 1,4'b0000,0,  0,0);
        vecs[2]  = mk(1,0,0,1,  96,7, 1,4'b0000,1,  0,0);
        vecs[3]  = mk(1,0,0,1,  55,1, 2,4'b1100,2,  0,0);
        vecs[4]  = mk(1,0,0,1,  40,3, 2,4'b1100,2,  0,0);
        vecs[5]  = mk(1,0,1,0,   0,0, 2,4'b1100,2,  0,0);
        vecs[6]  = mk(1,1,0,0,   0,0, 0,4'b0000,0,  0,0);
        vecs[7]  = mk(1,0,1,0,   0,0, 1,4'b0000,0,  0,0);
        vecs[8]  = mk(1,0,0,1,  99,0, 1,4'b0000,1,  0,0);
        vecs[9]  = mk(1,0,0,1, 100,0, 3,4'b1010,2,100,0);
        vecs[10] = mk(1,0,0,1,  55,1, 3,4'b1010,2,100,0);
        vecs[11] = mk(1,0,1,0,   0,0, 3,4'b1010,2,100,0);
        vecs[12] = mk(1,1,0,0,   0,0, 0,4'b0000,0,  0,0);
        vecs[13] = mk(1,0,1,0,   0,0, 1,4'b0000,0,  0,0);
        vecs[14] = mk(1,0,0,1,  55,2, 3,4'b1010,1, 55,2);
        vecs[15] = mk(1,1,1,0,   0,0, 0,4'b0000,0,  0,0);
        vecs[16] = mk(1,0,1,0,   0,0, 1,4'b0000,0,  0,0);
        vecs[17] = mk(1,1,0,1,  55,1, 0,4'b0000,0,  0,0);
        vecs[18] = mk(1,0,1,0,   0,0, 1,4'b0000,0,  0,0);
        vecs[19] = mk(1,0,0,1,  40,3, 3,4'b1010,1, 40,3);
        vecs[20] = mk(0,1,0,0,   0,0, 0,4'b0000,0,  0,0);
        vecs[21] = mk(1,0,1,0,   0,0, 1,4'b0000,0,  0,0);
        vecs[22] = mk(1,0,0,1,  97,5, 1,4'b0000,1,  0,0);
        vecs[23] = mk(0,0,0,0,   0,0, 0,4'b0000,0,  0,0);
        vecs[24] = mk(0,0,1,0,   0,0, 0,4'b0000,0,  0,0);
        vecs[25] = mk(1,0,1,0,   0,0, 1,4'b0000,0,  0,0);
        vecs[26] = mk(1,0,0,1,  95,0, 3,4'b1010,1, 95,0);
        vecs[27] = mk(1,1,0,0,   0,0, 0,4'b0000,0,  0,0);

        for (int i = 0; i < 28; i++) begin
            cyc(vecs[i].rn, vecs[i].cl, vecs[i].ar, vecs[i].mw, vecs[i].adr, vecs[i].dat);
            a = pack_act(0);
            a[55:32] = '0;
            e = {4'b0, vecs[i].e_flags, 6'b0, 2'(vecs[i].e_st), 24'(vecs[i].e_wc), 24'b0,
                 16'(vecs[i].e_fa), 16'(vecs[i].e_fd)};
            check($sformatf("vec%0d", i), a, e);
        end

        // Watchdog: expiry after exactly 8 RUN cycles with no stores.
        cyc(1,1,0,0,0,0);
        cyc(1,0,1,0,0,0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1,0,0,0,0,0);
            if (k < 8) check("wd_early", 96'({tout_s, status_s}), 96'({1'b0, 2'd1}));
            else       check("wd_fire",  96'({done_s, tout_s, fail_s, status_s}), 96'({1'b1, 1'b1, 1'b0, 2'd3}));
        end

        // Pass store on the expiry edge wins.
        cyc(1,1,0,0,0,0);
        cyc(1,0,1,0,0,0);
        for (int k = 1; k <= 7; k++) cyc(1,0,0,0,0,0);
        cyc(1,0,0,1,55,1);
        check("wd_pass_wins", 96'({pass_s, tout_s, status_s}), 96'({1'b1, 1'b0, 2'd2}));

        // Lenient instance: unmatched store tolerated, pass store ends run.
        cyc(1,1,0,0,0,0);
        cyc(1,0,1,0,0,0);
        cyc(1,0,0,1,40,3);
        cyc(1,0,0,1,55,1);
        check("lenient_pass", 96'({pass_n, fail_n, wc_n}), 96'({1'b1, 1'b0, 24'd2}));

        // Saturation: 10 ignored stores on a 3-bit counter.
        cyc(1,1,0,0,0,0);
        cyc(1,0,1,0,0,0);
        for (int k = 0; k < 10; k++) cyc(1,0,0,1,96,0);
        check("sat_wc", 96'({status_c, wc_c, cc_c}), 96'({2'd1, 3'd7, 3'd7}));

        // Randomised traffic against the models.
        cyc(1,1,0,0,0,0);
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 5))
                0: radr = 55;
                1: radr = 55;
                2: radr = $urandom_range(94, 101);
                3: radr = $urandom_range(100, 113);
                4: radr = $urandom_range(0, 8191);
                default: radr = $urandom_range(30, 60);
            endcase
            rdat = ($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(0, 3));
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, radr, rdat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
